// File: rtl/eq_gain_mixer.sv
// eq_gain_mixer: 10-band equalizer gain/sum through one time-shared signed multiplier.
// Revision 1.0
`default_nettype none

module eq_gain_mixer #(
  parameter int DATA_W = 24,
  parameter int GAIN_W = 16,
  parameter int FRAC   = 14,
  parameter int NBANDS = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_lp,
  input  logic signed [DATA_W-1:0] i_band_64_125,
  input  logic signed [DATA_W-1:0] i_band_125_250,
  input  logic signed [DATA_W-1:0] i_band_250_500,
  input  logic signed [DATA_W-1:0] i_band_500_1k,
  input  logic signed [DATA_W-1:0] i_band_1k_2k,
  input  logic signed [DATA_W-1:0] i_band_2k_4k,
  input  logic signed [DATA_W-1:0] i_band_4k_8k,
  input  logic signed [DATA_W-1:0] i_band_8k_16k,
  input  logic signed [DATA_W-1:0] i_hp,
  input  logic                     i_gain_we,
  input  logic [3:0]               i_gain_addr,
  input  logic signed [GAIN_W-1:0] i_gain_data,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_drop
);

  localparam int PROD_W = DATA_W + GAIN_W;
  localparam int ACC_W  = PROD_W + 4;
  localparam int CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [CNT_W-1:0]        LAST_BAND = CNT_W'(NBANDS - 1);
  localparam logic signed [GAIN_W-1:0] UNITY    = GAIN_W'(1 << FRAC);
  localparam logic signed [ACC_W-1:0]  SAT_MAX  =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  SAT_MIN  =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] band_in [NBANDS];
  logic signed [DATA_W-1:0] cap     [NBANDS];
  logic signed [GAIN_W-1:0] gain    [NBANDS];

  logic [1:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sat_val;

  assign band_in[0] = i_lp;
  assign band_in[1] = i_band_64_125;
  assign band_in[2] = i_band_125_250;
  assign band_in[3] = i_band_250_500;
  assign band_in[4] = i_band_500_1k;
  assign band_in[5] = i_band_1k_2k;
  assign band_in[6] = i_band_2k_4k;
  assign band_in[7] = i_band_4k_8k;
  assign band_in[8] = i_band_8k_16k;
  assign band_in[9] = i_hp;

  // Single shared multiplier, steered by the band counter.
  assign prod     = cap[cnt] * gain[cnt];
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign shifted  = acc >>> FRAC;
  assign o_busy   = (state != ST_IDLE);

  always_comb begin
    sat_val = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end
  end

  // Writes land at the edge; a MAC on the same edge still reads the old gain.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NBANDS; k++) begin
        gain[k] <= UNITY;
      end
    end else if (i_gain_we) begin
      for (int k = 0; k < NBANDS; k++) begin
        if (i_gain_addr == CNT_W'(k)) begin
          gain[k] <= i_gain_data;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NBANDS; k++) begin
        cap[k] <= '0;
      end
    end else if ((state == ST_IDLE) && i_en) begin
      for (int k = 0; k < NBANDS; k++) begin
        cap[k] <= band_in[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_drop  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_en) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          o_drop <= i_en;
          acc    <= acc + prod_ext;
          if (cnt == LAST_BAND) begin
            cnt   <= '0;
            state <= ST_OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_OUT: begin
          o_drop  <= i_en;
          o_data  <= sat_val;
          o_valid <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eq_gain_mixer.sv
// tb_eq_gain_mixer: directed table-driven bench for eq_gain_mixer.
// Revision 1.0
`default_nettype none

module tb_eq_gain_mixer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic signed [23:0] band [10];
  logic               we;
  logic [3:0]         addr;
  logic signed [15:0] gdata;
  logic signed [23:0] data;
  logic               valid;
  logic               busy;
  logic               drop;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [9:0][15:0] g;
    logic [9:0][23:0] b;
    logic [23:0]      exp;
  } vec_t;

  vec_t  vecs [7];
  string names [7];

  always #5 clk = ~clk;

  eq_gain_mixer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_en           (en),
    .i_lp           (band[0]),
    .i_band_64_125  (band[1]),
    .i_band_125_250 (band[2]),
    .i_band_250_500 (band[3]),
    .i_band_500_1k  (band[4]),
    .i_band_1k_2k   (band[5]),
    .i_band_2k_4k   (band[6]),
    .i_band_4k_8k   (band[7]),
    .i_band_8k_16k  (band[8]),
    .i_hp           (band[9]),
    .i_gain_we      (we),
    .i_gain_addr    (addr),
    .i_gain_data    (gdata),
    .o_data         (data),
    .o_valid        (valid),
    .o_busy         (busy),
    .o_drop         (drop)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic write_gain(input int a, input logic [15:0] d);
    @(negedge clk);
    we    = 1'b1;
    addr  = 4'(a);
    gdata = d;
    @(negedge clk);
    we    = 1'b0;
  endtask

  // One strobe, then scrambled inputs; checks latency, pulse count and value.
  task automatic do_sample(input string name, input logic [9:0][23:0] b, input longint exp);
    int lat;
    int nval;
    @(negedge clk);
    for (int k = 0; k < 10; k++) band[k] = b[k];
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 10; k++) band[k] = 24'h123456;
    lat  = 0;
    nval = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (valid) begin
        nval++;
        if (lat == 0) lat = k;
      end
    end
    chk({name, "_latency"}, lat, 11);
    chk({name, "_nvalid"}, nval, 1);
    chk({name, "_data"}, longint'($signed(data)), exp);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: actual=stalled required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int valk, nval, dropk, ndrop, b0, b10, b12;

    vecs[0].g = {10{16'd16384}};
    vecs[0].b = {10{24'd1000}};
    vecs[0].exp = 24'd10000;
    names[0] = "unity_sum";

    vecs[1].g = '0;
    vecs[1].g[0] = 16'd32767;
    vecs[1].b = {10{24'd5}};
    vecs[1].b[0] = 24'h7FFFFF;
    vecs[1].exp = 24'h7FFFFF;
    names[1] = "pos_sat";

    vecs[2].g = {10{16'd16384}};
    vecs[2].b = {10{24'h800000}};
    vecs[2].exp = 24'h800000;
    names[2] = "neg_sat";

    vecs[3].g = '0;
    vecs[3].g[9] = 16'd8192;
    vecs[3].b = {10{24'd77}};
    vecs[3].b[9] = 24'hFFFFFF;
    vecs[3].exp = 24'hFFFFFF;
    names[3] = "floor_neg";

    vecs[4].g = '0;
    vecs[4].g[9] = 16'd8192;
    vecs[4].b = {10{24'd77}};
    vecs[4].b[9] = 24'd1;
    vecs[4].exp = 24'd0;
    names[4] = "floor_pos";

    // 100 - 30 - 7*0.25 = 68.25 -> 68
    vecs[5].g = '0;
    vecs[5].g[0] = 16'd16384;
    vecs[5].g[1] = 16'hC000;
    vecs[5].g[2] = 16'd4096;
    vecs[5].b = {10{24'd9}};
    vecs[5].b[0] = 24'd100;
    vecs[5].b[1] = 24'd30;
    vecs[5].b[2] = 24'hFFFFF9;
    vecs[5].exp = 24'd68;
    names[5] = "mixed";

    // -0.5 * (1+..+10) = -27.5 -> -28
    vecs[6].g = {10{16'hE000}};
    for (int k = 0; k < 10; k++) vecs[6].b[k] = 24'(k + 1);
    vecs[6].exp = 24'hFFFFE4;
    names[6] = "neg_gain";

    // Reset with strobe and gain writes held active; both must be ignored.
    rst_n = 1'b0;
    en    = 1'b1;
    we    = 1'b1;
    gdata = '0;
    addr  = '0;
    for (int k = 0; k < 10; k++) band[k] = 24'd1000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      addr = 4'(k);
    end
    @(negedge clk);
    chk("rst_data", longint'($signed(data)), 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    rst_n = 1'b1;
    en    = 1'b0;
    we    = 1'b0;

    // Unity sum straight out of reset with a detailed timing trace.
    @(negedge clk);
    chk("A_busy_before", busy, 0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    b0 = busy;
    valk = 0; nval = 0; b10 = 0; b12 = 1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (valid) begin
        nval++;
        valk = k;
      end
      if (k == 10) b10 = busy;
      if (k == 12) b12 = busy;
    end
    chk("A_busy_k0", b0, 1);
    chk("A_busy_k10", b10, 1);
    chk("A_busy_k12", b12, 0);
    chk("A_valid_at", valk, 11);
    chk("A_nvalid", nval, 1);
    chk("A_data", longint'($signed(data)), 10000);

    // Table: program gains, junk-write an out-of-range address, run one sample.
    for (int i = 0; i < 7; i++) begin
      for (int a = 0; a < 10; a++) write_gain(a, vecs[i].g[a]);
      write_gain(10 + (i % 6), 16'd0);
      do_sample(names[i], vecs[i].b, longint'($signed(vecs[i].exp)));
    end

    // Overrun at N+4 and a gain[5] write on the band-5 MAC edge (N+6).
    for (int a = 0; a < 10; a++) write_gain(a, 16'd16384);
    @(negedge clk);
    for (int k = 0; k < 10; k++) band[k] = 24'd1000;
    en = 1'b1;
    valk = 0; nval = 0; dropk = 0; ndrop = 0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (drop) begin
        ndrop++;
        dropk = k;
      end
      if (valid) begin
        nval++;
        valk = k;
      end
      en = (k == 3);
      if (k == 3) for (int j = 0; j < 10; j++) band[j] = 24'd5;
      we    = (k == 5);
      addr  = 4'd5;
      gdata = 16'd0;
    end
    chk("B_drop_at", dropk, 4);
    chk("B_ndrop", ndrop, 1);
    chk("B_valid_at", valk, 11);
    chk("B_nvalid", nval, 1);
    chk("B_data", longint'($signed(data)), 10000);
    do_sample("B_next", {10{24'd1000}}, 9000);

    // Reset at edge N+5 aborts the sample and restores unity gains.
    @(negedge clk);
    for (int k = 0; k < 10; k++) band[k] = 24'd1000;
    en = 1'b1;
    nval = 0;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (valid) nval++;
      en    = 1'b0;
      rst_n = (k != 4);
    end
    chk("C_nvalid", nval, 0);
    chk("C_data", longint'($signed(data)), 0);
    chk("C_busy", busy, 0);
    do_sample("C_after", {10{24'd1}}, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
